// File: rtl/encoder_8x3_stream_pkg.sv
// Shared definitions for the streaming set-bit encoder: state encoding and
// the elaboration-time log2 used to size the index port.
package enc_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_8x3_stream_pri_enc.sv
// Combinational N->W priority encoder; direction chosen by PRIORITY_HIGH.
// idx is 0 when no bit is set, with any flagging that case.
module pri_enc
  import enc_pkg::*;
#(
  parameter int N             = 8,
  parameter bit PRIORITY_HIGH = 1'b1,
  localparam int W            = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |vec;
    if (PRIORITY_HIGH) begin
      // Ascending scan: the last hit, i.e. the highest set bit, wins.
      for (int k = 0; k < N; k++) begin
        if (vec[k]) idx = W'(k);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (vec[k]) idx = W'(k);
      end
    end
  end

endmodule

// File: rtl/encoder_8x3_stream.sv
// Streams the index of every set bit of an accepted request vector, one beat
// per output handshake; an all-zero vector yields a single flagged beat.
module encoder_8x3_stream
  import enc_pkg::*;
#(
  parameter int N             = 8,
  parameter bit PRIORITY_HIGH = 1'b1,
  localparam int W            = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         out_last,
  output logic         out_zero
);

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   y_q, y_d;
  logic           out_last_q, out_last_d;
  logic           out_zero_q, out_zero_d;

  logic           accept;
  logic           beat_hs;
  logic           load_beat;
  logic [W-1:0]   enc_idx;
  logic           enc_any;
  logic           single_bit;

  assign beat_hs  = out_valid_q & out_ready;
  assign in_ready = (state_q == S_IDLE) | (beat_hs & out_last_q);
  assign accept   = in_valid & in_ready;

  // pending holds the bits still to be emitted, including the one on y.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    load_beat   = 1'b0;
    if (accept) begin
      state_d     = S_BUSY;
      pending_d   = i;
      out_valid_d = 1'b1;
      load_beat   = 1'b1;
    end else if (beat_hs) begin
      if (out_last_q) begin
        state_d     = S_IDLE;
        pending_d   = '0;
        out_valid_d = 1'b0;
      end else begin
        pending_d = pending_q & ~(N'(1) << y_q);
        load_beat = 1'b1;
      end
    end
  end

  pri_enc #(
    .N            (N),
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_pri_enc (
    .vec(pending_d),
    .idx(enc_idx),
    .any(enc_any)
  );

  // Zero also counts as "single": the all-zero vector is one final beat.
  assign single_bit = (pending_d & (pending_d - N'(1))) == '0;

  always_comb begin
    y_d        = y_q;
    out_last_d = out_last_q;
    out_zero_d = out_zero_q;
    if (load_beat) begin
      y_d        = enc_idx;
      out_last_d = single_bit;
      out_zero_d = ~enc_any;
    end else if (beat_hs & out_last_q) begin
      y_d        = '0;
      out_last_d = 1'b0;
      out_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_encoder_8x3_stream.sv
// Scoreboard bench for encoder_8x3_stream: high- and low-priority instances
// share stimulus; expected beats are queued on accept and popped on handshake.
module tb_encoder_8x3_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] i;
  logic       out_ready;

  logic       in_ready_hi, out_valid_hi, out_last_hi, out_zero_hi;
  logic [2:0] y_hi;
  logic       in_ready_lo, out_valid_lo, out_last_lo, out_zero_lo;
  logic [2:0] y_lo;

  typedef struct packed {
    logic [2:0] y;
    logic       last;
    logic       zero;
  } beat_t;

  beat_t q_hi[$];
  beat_t q_lo[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic  rst_prev_low = 1'b0;
  logic  stall_prev   = 1'b0;
  beat_t stall_val_hi;
  beat_t stall_val_lo;

  encoder_8x3_stream #(.N(8), .PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_hi),
    .i(i), .out_valid(out_valid_hi), .out_ready(out_ready), .y(y_hi),
    .out_last(out_last_hi), .out_zero(out_zero_hi)
  );

  encoder_8x3_stream #(.N(8), .PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_lo),
    .i(i), .out_valid(out_valid_lo), .out_ready(out_ready), .y(y_lo),
    .out_last(out_last_lo), .out_zero(out_zero_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_vec(input logic [7:0] v);
    int rem;
    if (v == 8'h00) begin
      q_hi.push_back(beat_t'{y: 3'd0, last: 1'b1, zero: 1'b1});
      q_lo.push_back(beat_t'{y: 3'd0, last: 1'b1, zero: 1'b1});
    end else begin
      rem = $countones(v);
      for (int b = 7; b >= 0; b--) begin
        if (v[b]) begin
          q_hi.push_back(beat_t'{y: 3'(b), last: (rem == 1), zero: 1'b0});
          rem--;
        end
      end
      rem = $countones(v);
      for (int b = 0; b < 8; b++) begin
        if (v[b]) begin
          q_lo.push_back(beat_t'{y: 3'(b), last: (rem == 1), zero: 1'b0});
          rem--;
        end
      end
    end
  endfunction

  // Monitor: inputs only change just after posedge, so values seen here are
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    beat_t exp_b;
    logic  exp_ready;
    if (!rst_n) begin
      if (rst_prev_low) begin
        check_eq("rst_out_valid", {out_valid_hi, out_valid_lo}, 2'b00);
        check_eq("rst_y", {y_hi, y_lo}, 6'd0);
      end
      q_hi.delete();
      q_lo.delete();
      rst_prev_low = 1'b1;
      stall_prev   = 1'b0;
    end else begin
      rst_prev_low = 1'b0;
      check_eq("valid_hi", out_valid_hi, q_hi.size() != 0);
      check_eq("valid_lo", out_valid_lo, q_lo.size() != 0);
      exp_ready = (q_hi.size() == 0) || (out_ready && q_hi.size() == 1);
      check_eq("in_ready_hi", in_ready_hi, exp_ready);
      check_eq("in_ready_lo", in_ready_lo, exp_ready);
      if (stall_prev) begin
        check_eq("stall_hold_hi", {y_hi, out_last_hi, out_zero_hi}, stall_val_hi);
        check_eq("stall_hold_lo", {y_lo, out_last_lo, out_zero_lo}, stall_val_lo);
      end
      if (out_valid_hi && out_ready && q_hi.size() != 0) begin
        exp_b = q_hi.pop_front();
        $display("beat hi y=%0d last=%0b zero=%0b", y_hi, out_last_hi, out_zero_hi);
        check_eq("beat_hi", {y_hi, out_last_hi, out_zero_hi}, exp_b);
      end
      if (out_valid_lo && out_ready && q_lo.size() != 0) begin
        exp_b = q_lo.pop_front();
        $display("beat lo y=%0d last=%0b zero=%0b", y_lo, out_last_lo, out_zero_lo);
        check_eq("beat_lo", {y_lo, out_last_lo, out_zero_lo}, exp_b);
      end
      if (in_valid && in_ready_hi) begin
        $display("accept vec=0x%02h", i);
        push_vec(i);
      end
      stall_prev   = out_valid_hi && !out_ready;
      stall_val_hi = {y_hi, out_last_hi, out_zero_hi};
      stall_val_lo = {y_lo, out_last_lo, out_zero_lo};
    end
  end

  // Present v until accepted; keep in_valid high afterwards if keep is set.
  task automatic send(input logic [7:0] v, input bit keep);
    int t;
    in_valid = 1'b1;
    i        = v;
    t        = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready_hi) break;
      t++;
      if (t > 200) begin
        check_eq("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q_hi.size() != 0 || out_valid_hi) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        check_eq("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit rnd_done;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    i         = 8'hFF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out_valid", out_valid_hi, 1'b0);
    check_eq("reset_y", y_hi, 3'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", in_ready_hi, 1'b1);
    @(posedge clk);
    #1;

    // Single bit: beat appears one cycle after accept.
    send(8'b0000_0100, 1'b0);
    check_eq("single_first_beat", {out_valid_hi, y_hi, out_last_hi, out_zero_hi}, {1'b1, 3'd2, 1'b1, 1'b0});
    wait_idle();

    send(8'b1010_0001, 1'b0);
    check_eq("multi_first_hi", y_hi, 3'd7);
    check_eq("multi_first_lo", y_lo, 3'd0);
    wait_idle();

    // Backpressure on beat y=5.
    send(8'b1010_0001, 1'b0);
    for (int t = 0; t < 10 && y_hi != 3'd5; t++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_y5", {out_valid_hi, y_hi}, {1'b1, 3'd5});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("after_hold_y0", {out_valid_hi, y_hi, out_last_hi}, {1'b1, 3'd0, 1'b1});
    wait_idle();

    send(8'h00, 1'b0);
    check_eq("zero_beat", {out_valid_hi, y_hi, out_last_hi, out_zero_hi}, {1'b1, 3'd0, 1'b1, 1'b1});
    wait_idle();

    // Back-to-back with in_valid held.
    send(8'h03, 1'b1);
    i = 8'h80;
    send(8'h80, 1'b0);
    wait_idle();

    // Reset in the middle of an 8'hFF stream.
    send(8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_reset_no_beat", out_valid_hi | out_valid_lo, 1'b0);

    // Random vectors under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          send(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), 1'b0);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
